// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes and the
// function that picks a cause when restart events coincide.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT    = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_POR  = 2'b00;
  localparam cause_t CAUSE_SW   = 2'b01;
  localparam cause_t CAUSE_WDT  = 2'b10;
  localparam cause_t CAUSE_LOCK = 2'b11;

  // Watchdog wins over software, which wins over lock loss.
  function automatic cause_t restart_cause(input logic wdt, input logic sw);
    if (wdt)     return CAUSE_WDT;
    else if (sw) return CAUSE_SW;
    else         return CAUSE_LOCK;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Reset-request inputs and per-domain reset outputs of the reset sequencer.
interface reset_seq_if #(
  parameter int unsigned N_DOM = 4
);
  import reset_seq_pkg::*;

  logic             pll_lock;
  logic             sw_req;
  logic             wdt_req;
  logic [N_DOM-1:0] dom_rst_n;
  logic             rst_done;
  cause_t           rst_cause;

  modport master (
    output pll_lock, sw_req, wdt_req,
    input  dom_rst_n, rst_done, rst_cause
  );

  modport slave (
    input  pll_lock, sw_req, wdt_req,
    output dom_rst_n, rst_done, rst_cause
  );

endinterface

// File: rtl/reset_step_counter.sv
// Saturating step counter with synchronous clear; o_tc_c flags the terminal count.
module reset_step_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_tc_val,
  output logic             o_tc_c
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tc_c = (r_cnt == i_tc_val);

  // Stops at the terminal count rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Holds all reset domains, waits for PLL lock, then releases domains 0..N_DOM-1
// in order, STEP_CYC cycles apart; restarts on SW/WDT request or lock loss.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_DOM    = 4,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned STEP_CYC = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  reset_seq_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_DOM) + 1;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [N_DOM-1:0] r_dom_rst_n;
  logic             r_rst_done;
  cause_t           r_rst_cause;

  logic             w_restart;
  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_last;
  logic [CNT_W-1:0] w_tc_val;

  // Lock loss only counts once domains have started coming out of reset.
  assign w_restart = bus.wdt_req | bus.sw_req |
                     (~bus.pll_lock & ((r_state == RELEASE) || (r_state == RUN)));

  assign w_tc_val  = (r_state == RELEASE) ? CNT_W'(STEP_CYC - 1) : CNT_W'(HOLD_CYC - 1);
  assign w_cnt_en  = (r_state == ASSERT) || (r_state == RELEASE);
  assign w_cnt_clr = w_restart | w_tc | (r_state == WAIT_LOCK);
  assign w_last    = (r_idx == IDX_W'(N_DOM - 1));

  reset_step_counter #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .i_tc_val (w_tc_val),
    .o_tc_c   (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ASSERT;
      r_idx       <= '0;
      r_dom_rst_n <= '0;
      r_rst_done  <= 1'b0;
      r_rst_cause <= CAUSE_POR;
    end else if (w_restart) begin
      r_state     <= ASSERT;
      r_idx       <= '0;
      r_dom_rst_n <= '0;
      r_rst_done  <= 1'b0;
      r_rst_cause <= restart_cause(bus.wdt_req, bus.sw_req);
    end else begin
      case (r_state)
        ASSERT: begin
          if (w_tc) begin
            if (bus.pll_lock) begin
              r_state        <= RELEASE;
              r_dom_rst_n[0] <= 1'b1;
            end else begin
              r_state <= WAIT_LOCK;
            end
          end
        end
        WAIT_LOCK: begin
          if (bus.pll_lock) begin
            r_state        <= RELEASE;
            r_dom_rst_n[0] <= 1'b1;
          end
        end
        RELEASE: begin
          if (w_tc) begin
            if (w_last) begin
              r_state    <= RUN;
              r_rst_done <= 1'b1;
            end else begin
              r_idx       <= r_idx + IDX_W'(1);
              r_dom_rst_n <= r_dom_rst_n | (N_DOM'(1) << (r_idx + IDX_W'(1)));
            end
          end
        end
        RUN:     r_state <= RUN;
        default: r_state <= ASSERT;
      endcase
    end
  end

  assign bus.dom_rst_n = r_dom_rst_n;
  assign bus.rst_done  = r_rst_done;
  assign bus.rst_cause = r_rst_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random
// request/lock traffic, all compared against an event-time reference model.
module tb_reset_sequencer;

  localparam int unsigned N_DOM    = 4;
  localparam int unsigned HOLD_CYC = 16;
  localparam int unsigned STEP_CYC = 8;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned OW       = N_DOM + 3;

  logic clk = 1'b0;
  logic rst;

  reset_seq_if #(.N_DOM(N_DOM)) bus ();

  reset_sequencer #(
    .N_DOM    (N_DOM),
    .HOLD_CYC (HOLD_CYC),
    .STEP_CYC (STEP_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: edge of the last (re)start, edge of the first domain release (-1 if
  // none yet) and the latched cause; outputs follow from elapsed edges alone.
  longint     edge_n  = 0;
  longint     m_start = 0;
  longint     m_rel   = -1;
  logic [1:0] m_cause = 2'b00;

  function automatic logic [OW-1:0] exp_out();
    logic [N_DOM-1:0] dom;
    logic             done;
    for (int i = 0; i < N_DOM; i++)
      dom[i] = (m_rel >= 0) && (edge_n >= m_rel + longint'(i * STEP_CYC));
    done = (m_rel >= 0) && (edge_n >= m_rel + longint'(N_DOM * STEP_CYC));
    return {m_cause, done, dom};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.rst_cause, bus.rst_done, bus.dom_rst_n};
  endfunction

  // Apply inputs for one clock edge and advance the model over that edge.
  task automatic drv(input logic r, input logic l, input logic s, input logic w);
    @(negedge clk);
    rst = r; bus.pll_lock = l; bus.sw_req = s; bus.wdt_req = w;
    @(posedge clk);
    edge_n++;
    if (r) begin
      m_start = edge_n; m_rel = -1; m_cause = 2'b00;
    end else if (w || s || (!l && m_rel >= 0)) begin
      m_start = edge_n; m_rel = -1;
      m_cause = w ? 2'b10 : (s ? 2'b01 : 2'b11);
    end else if (m_rel < 0 && l && edge_n >= m_start + longint'(HOLD_CYC)) begin
      m_rel = edge_n;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) drv(1'b1, 1'b1, 1'b1, 1'b1);
    n_chk++;
    if (dut_out() !== OW'(0)) begin
      n_fail++; $display("FAIL reset_values got %b exp %b", dut_out(), OW'(0));
    end
  endtask

  task automatic test_por();
    int rise[N_DOM];
    int done_e = -1;
    for (int i = 0; i < N_DOM; i++) rise[i] = -1;
    drv(1'b1, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 60; e++) begin
      drv(1'b0, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if (dut_out() !== exp_out()) begin
        n_fail++; $display("FAIL por_model e=%0d got %b exp %b", e, dut_out(), exp_out());
      end
      for (int i = 0; i < N_DOM; i++) if (bus.dom_rst_n[i] === 1'b1 && rise[i] < 0) rise[i] = e;
      if (bus.rst_done === 1'b1 && done_e < 0) done_e = e;
    end
    for (int i = 0; i < N_DOM; i++) begin
      n_chk++;
      if (rise[i] !== 16 + i * 8) begin
        n_fail++; $display("FAIL por_rise%0d got %0d exp %0d", i, rise[i], 16 + i * 8);
      end
    end
    n_chk++;
    if (done_e !== 48 || bus.rst_cause !== 2'b00) begin
      n_fail++; $display("FAIL por_done got %0d/%b exp 48/00", done_e, bus.rst_cause);
    end
  endtask

  task automatic test_lock_wait();
    int rise0 = -1;
    int done_e = -1;
    drv(1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 70; e++) begin
      drv(1'b0, logic'(e >= 31), 1'b0, 1'b0);
      n_chk++;
      if (dut_out() !== exp_out()) begin
        n_fail++; $display("FAIL lock_model e=%0d got %b exp %b", e, dut_out(), exp_out());
      end
      if (e == 20) begin
        n_chk++;
        if (bus.dom_rst_n !== 4'b0000) begin
          n_fail++; $display("FAIL lock_wait_hold got %b exp 0000", bus.dom_rst_n);
        end
      end
      if (bus.dom_rst_n[0] === 1'b1 && rise0 < 0) rise0 = e;
      if (bus.rst_done === 1'b1 && done_e < 0) done_e = e;
    end
    n_chk++;
    if (rise0 !== 31 || done_e !== 63) begin
      n_fail++; $display("FAIL lock_wait_timing got %0d/%0d exp 31/63", rise0, done_e);
    end
  endtask

  // Continues from the RUN state left by test_lock_wait (local edge 70).
  task automatic test_sw_restart();
    int rise0 = -1;
    int done_e = -1;
    for (int e = 71; e <= 150; e++) begin
      drv(1'b0, 1'b1, logic'(e == 101), 1'b0);
      n_chk++;
      if (dut_out() !== exp_out()) begin
        n_fail++; $display("FAIL sw_model e=%0d got %b exp %b", e, dut_out(), exp_out());
      end
      if (e == 101) begin
        n_chk++;
        if (dut_out() !== {2'b01, 1'b0, 4'b0000}) begin
          n_fail++; $display("FAIL sw_restart_edge got %b exp 0100000", dut_out());
        end
      end
      if (e > 101 && bus.dom_rst_n[0] === 1'b1 && rise0 < 0) rise0 = e;
      if (e > 101 && bus.rst_done === 1'b1 && done_e < 0) done_e = e;
    end
    n_chk++;
    if (rise0 !== 117 || done_e !== 149) begin
      n_fail++; $display("FAIL sw_timing got %0d/%0d exp 117/149", rise0, done_e);
    end
  endtask

  task automatic test_coincident();
    drv(1'b1, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 40; e++) begin
      drv(1'b0, 1'b1, logic'(e == 29), logic'(e == 29));
      n_chk++;
      if (dut_out() !== exp_out()) begin
        n_fail++; $display("FAIL coin_model e=%0d got %b exp %b", e, dut_out(), exp_out());
      end
      if (e == 28) begin
        n_chk++;
        if (bus.dom_rst_n !== 4'b0011) begin
          n_fail++; $display("FAIL coin_pre got %b exp 0011", bus.dom_rst_n);
        end
      end
      if (e == 29) begin
        n_chk++;
        if (dut_out() !== {2'b10, 1'b0, 4'b0000}) begin
          n_fail++; $display("FAIL coin_wdt_wins got %b exp 1000000", dut_out());
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    int rise[N_DOM];
    int done_e = -1;
    for (int i = 0; i < N_DOM; i++) rise[i] = -1;
    drv(1'b1, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 110; e++) begin
      drv(1'b0, logic'(e != 51), 1'b0, 1'b0);
      n_chk++;
      if (dut_out() !== exp_out()) begin
        n_fail++; $display("FAIL loss_model e=%0d got %b exp %b", e, dut_out(), exp_out());
      end
      if (e == 51) begin
        n_chk++;
        if (dut_out() !== {2'b11, 1'b0, 4'b0000}) begin
          n_fail++; $display("FAIL loss_edge got %b exp 1100000", dut_out());
        end
      end
      if (e > 51) begin
        for (int i = 0; i < N_DOM; i++) if (bus.dom_rst_n[i] === 1'b1 && rise[i] < 0) rise[i] = e;
        if (bus.rst_done === 1'b1 && done_e < 0) done_e = e;
      end
    end
    for (int i = 0; i < N_DOM; i++) begin
      n_chk++;
      if (rise[i] !== 67 + i * 8) begin
        n_fail++; $display("FAIL loss_rise%0d got %0d exp %0d", i, rise[i], 67 + i * 8);
      end
    end
    n_chk++;
    if (done_e !== 99) begin
      n_fail++; $display("FAIL loss_done got %0d exp 99", done_e);
    end
  endtask

  task automatic test_rst_mid_release();
    int rise0 = -1;
    drv(1'b1, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 90; e++) begin
      drv(logic'(e == 30), 1'b1, 1'b0, logic'(e == 6 || (e >= 31 && e <= 35)));
      n_chk++;
      if (dut_out() !== exp_out()) begin
        n_fail++; $display("FAIL rstmid_model e=%0d got %b exp %b", e, dut_out(), exp_out());
      end
      if (e == 29) begin
        n_chk++;
        if (dut_out() !== {2'b10, 1'b0, 4'b0001}) begin
          n_fail++; $display("FAIL rstmid_pre got %b exp 1000001", dut_out());
        end
      end
      if (e == 30) begin
        n_chk++;
        if (dut_out() !== OW'(0)) begin
          n_fail++; $display("FAIL rstmid_edge got %b exp 0000000", dut_out());
        end
      end
      if (e > 30 && bus.dom_rst_n[0] === 1'b1 && rise0 < 0) rise0 = e;
    end
    n_chk++;
    if (rise0 !== 51 || bus.rst_cause !== 2'b10) begin
      n_fail++; $display("FAIL wdt_level_hold got %0d/%b exp 51/10", rise0, bus.rst_cause);
    end
  endtask

  task automatic test_random();
    logic lk = 1'b1;
    drv(1'b1, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 3000; e++) begin
      if (lk) lk = ($urandom_range(0, 149) != 0);
      else    lk = ($urandom_range(0, 9) == 0);
      drv(logic'($urandom_range(0, 299) == 0), lk,
          logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 149) == 0));
      n_chk++;
      if (dut_out() !== exp_out()) begin
        n_fail++; $display("FAIL rand_model e=%0d got %b exp %b", e, dut_out(), exp_out());
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.pll_lock = 1'b0; bus.sw_req = 1'b0; bus.wdt_req = 1'b0;
    test_reset();
    test_por();
    test_lock_wait();
    test_sw_restart();
    test_coincident();
    test_lock_loss();
    test_rst_mid_release();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
